// File: rtl/alu_pkg.sv
// Shared ALU constants, partial-product types and the shifted partial-product
// reduction used by the multiplier.
package alu_pkg;
   localparam int ALU_WIDTH   = 32;
   localparam int MUL_LATENCY = 2;
   localparam int PP_SLICE    = 8;
   localparam int NUM_PP      = ALU_WIDTH / PP_SLICE;
   localparam int PP_WIDTH    = ALU_WIDTH + PP_SLICE;

   typedef logic [PP_WIDTH-1:0]              pp_t;
   typedef logic [NUM_PP-1:0][PP_WIDTH-1:0]  pp_vec_t;
   typedef logic [2*ALU_WIDTH-1:0]           full_t;

   // Row k carries weight 2^(8k); each row is zero-extended to the full product width.
   function automatic full_t pp_sum(input pp_vec_t pp);
      full_t acc;
      acc = '0;
      for (int k = 0; k < NUM_PP; k++) begin
         acc = acc + ({{(2*ALU_WIDTH-PP_WIDTH){1'b0}}, pp[k]} << (PP_SLICE * k));
      end
      return acc;
   endfunction
endpackage

// File: rtl/multiplier_if.sv
// Operand/result bundle between the ALU issue logic and the multiplier.
interface multiplier_if;
   import alu_pkg::*;

   logic                 in_valid;
   logic [ALU_WIDTH-1:0] r2;
   logic [ALU_WIDTH-1:0] r3;
   logic [ALU_WIDTH-1:0] r1;
   logic                 ovf;
   logic                 out_valid;

   modport master (output in_valid, r2, r3, input  r1, ovf, out_valid);
   modport slave  (input  in_valid, r2, r3, output r1, ovf, out_valid);
endinterface

// File: rtl/mul_pp_row.sv
// Combinational WIDTH x 8 partial-product row.
module mul_pp_row
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0]          a,
   input  logic [PP_SLICE-1:0]       b,
   output logic [WIDTH+PP_SLICE-1:0] p
);
   assign p = {{PP_SLICE{1'b0}}, a} * {{WIDTH{1'b0}}, b};
endmodule

// File: rtl/multiplier.sv
// Two-stage pipelined unsigned 32x32 multiplier: byte-sliced partial products,
// then shifted accumulation with low-word result and overflow flag.
module multiplier
   import alu_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   multiplier_if.slave  bus
);
   pp_vec_t pp_row;
   pp_vec_t pp;
   logic    v1;
   full_t   full;

   for (genvar k = 0; k < NUM_PP; k++) begin : g_row
      mul_pp_row #(.WIDTH(ALU_WIDTH)) u_row (
         .a (bus.r2),
         .b (bus.r3[PP_SLICE*k +: PP_SLICE]),
         .p (pp_row[k])
      );
   end

   // Stage 1: capture partial products only for valid pairs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pp <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= bus.in_valid;
         if (bus.in_valid) begin
            pp <= pp_row;
         end
      end
   end

   // Shifted four-row adder between the pipeline stages.
   always_comb begin
      full = pp_sum(pp);
   end

   // Stage 2: results update only when a valid pair arrives; otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.r1        <= '0;
         bus.ovf       <= 1'b0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= v1;
         if (v1) begin
            bus.r1  <= full[ALU_WIDTH-1:0];
            bus.ovf <= |full[2*ALU_WIDTH-1:ALU_WIDTH];
         end
      end
   end
endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for the pipelined multiplier: the driver queues expected
// results with their due cycle, a monitor compares every cycle.
module tb_multiplier;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   multiplier_if bus();

   multiplier u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] r1;
      logic        ovf;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] hold_r1 = 32'd0;
   logic        hold_ovf = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic send(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e_r1, input logic e_ovf, input bit push);
      @(negedge clk);
      bus.in_valid = v;
      bus.r2       = a;
      bus.r3       = b;
      if (v && push) exp_q.push_back('{e_r1, e_ovf, cyc + MUL_LATENCY});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send(1'b0, $urandom, $urandom, 32'd0, 1'b0, 1'b0);
   endtask

   // Monitor: every cycle, check out_valid against the scoreboard and r1/ovf
   // against either the due result or the held value.
   initial begin : monitor
      exp_t e;
      logic ev;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
            chk("rst_r1", {32'd0, bus.r1}, 64'd0);
            chk("rst_ovf", {63'd0, bus.ovf}, 64'd0);
            hold_r1  = 32'd0;
            hold_ovf = 1'b0;
         end else begin
            ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, ev});
            if (ev) begin
               e = exp_q.pop_front();
               chk("r1", {32'd0, bus.r1}, {32'd0, e.r1});
               chk("ovf", {63'd0, bus.ovf}, {63'd0, e.ovf});
               hold_r1  = e.r1;
               hold_ovf = e.ovf;
            end else begin
               chk("hold_r1", {32'd0, bus.r1}, {32'd0, hold_r1});
               chk("hold_ovf", {63'd0, bus.ovf}, {63'd0, hold_ovf});
            end
         end
      end
   end

   initial begin : driver
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
      bus.in_valid = 1'b0;
      bus.r2       = 32'd0;
      bus.r3       = 32'd0;

      // Reset, then idle: outputs stay zero.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(4);

      // Back-to-back pairs.
      send(1'b1, 32'd1, 32'd1, 32'd1, 1'b0, 1'b1);
      send(1'b1, 32'd2, 32'd1, 32'd2, 1'b0, 1'b1);
      send(1'b1, 32'd4, 32'd2, 32'd8, 1'b0, 1'b1);
      send(1'b1, 32'd8, 32'd1, 32'd8, 1'b0, 1'b1);

      // Overflow and boundary products.
      send(1'b1, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b1, 1'b1);
      send(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);
      send(1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b1);
      send(1'b1, 32'h1234_5678, 32'd0,         32'h0000_0000, 1'b0, 1'b1);
      send(1'b1, 32'd0,         32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
      send(1'b1, 32'h0001_0000, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b1);

      // Valid, gap, valid: r1 holds 15 during the gap.
      send(1'b1, 32'd3, 32'd5, 32'd15, 1'b0, 1'b1);
      idle(1);
      send(1'b1, 32'd7, 32'd9, 32'd63, 1'b0, 1'b1);
      idle(4);

      // Reset while (6,7) is in flight: it must never emerge.
      send(1'b1, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
      @(negedge clk);
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      chk("async_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("async_rst_r1", {32'd0, bus.r1}, 64'd0);
      chk("async_rst_ovf", {63'd0, bus.ovf}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(4);

      // Random pairs against a 64-bit reference product, with occasional gaps.
      for (int i = 0; i < 1000; i++) begin
         a = $urandom;
         b = $urandom;
         if ((i % 4) == 1) b = b >> $urandom_range(0, 31);
         p = {32'd0, a} * {32'd0, b};
         send(1'b1, a, b, p[31:0], |p[63:32], 1'b1);
         if ($urandom_range(0, 7) == 0) idle(1);
      end
      idle(4);
      chk("drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
